// File: rtl/cube_pkg.sv
// Shared encodings, command bundle and quarter-turn helpers
// for the cube rotation coprocessor.
package cube_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int MAX_FW    = 16;
  localparam int MAX_W     = NUM_SLOTS * MAX_FW;

  typedef enum logic [1:0] {
    OP_ROT   = 2'd0,
    OP_CHECK = 2'd1,
    OP_REF   = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    AX_X   = 2'd0,
    AX_Y   = 2'd1,
    AX_Z   = 2'd2,
    AX_RSV = 2'd3
  } axis_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } fsm_e;

  typedef struct packed {
    op_e        op;
    axis_e      axis;
    logic [1:0] turns;
    logic [2:0] slot;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Source slot per destination, slot 7 in the top 3 bits.
  localparam logic [23:0] SRC_X =
    {3'd3, 3'd6, 3'd7, 3'd4, 3'd1, 3'd2, 3'd5, 3'd0};
  localparam logic [23:0] SRC_Y =
    {3'd6, 3'd2, 3'd5, 3'd4, 3'd7, 3'd3, 3'd1, 3'd0};
  localparam logic [23:0] SRC_Z =
    {3'd5, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] SRC_I =
    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  function automatic int src_idx(input axis_e ax,
                                 input int d);
    logic [23:0] t;
    unique case (ax)
      AX_X:    t = SRC_X;
      AX_Y:    t = SRC_Y;
      AX_Z:    t = SRC_Z;
      default: t = SRC_I;
    endcase
    return int'(t[d*3 +: 3]);
  endfunction

  // State is zero-extended to MAX_W; fw selects the live slot width.
  function automatic logic [MAX_W-1:0] rot_q(
    input logic [MAX_W-1:0] s,
    input axis_e            ax,
    input int               fw
  );
    logic [MAX_W-1:0] r;
    int               src;
    r = s;
    for (int d = 0; d < NUM_SLOTS; d++) begin
      src = src_idx(ax, d);
      for (int b = 0; b < MAX_FW; b++) begin
        if (b < fw) r[d*fw + b] = s[src*fw + b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cube_cmd_fifo.sv
// Command queue between the CPU handshake and the rotation FSM.
// Count register disambiguates full from empty.
module cube_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    dout    = mem_q[rd_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cube_rot_engine.sv
// Cube state coprocessor: queued rotations, checks and slot reads,
// one quarter turn per clock.
module cube_rot_engine
  import cube_pkg::*;
#(
  parameter int FIELD_W    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [8*FIELD_W-1:0] state_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [1:0]           cmd_axis,
  input  logic [1:0]           cmd_turns,
  input  logic [2:0]           cmd_slot,
  input  logic [8*FIELD_W-1:0] solved_ref,
  output logic [8*FIELD_W-1:0] state,
  output logic                 busy,
  output logic                 done,
  output logic                 zf,
  output logic [FIELD_W-1:0]   ref_out,
  output logic                 err
);

  localparam int W = NUM_SLOTS * FIELD_W;

  function automatic logic [W-1:0] ident();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_SLOTS; i++)
      r[i*FIELD_W +: FIELD_W] = FIELD_W'(i);
    return r;
  endfunction

  localparam logic [W-1:0] IDENT = ident();

  fsm_e               fsm_q, fsm_d;
  logic [1:0]         cnt_q, cnt_d;
  op_e                op_q, op_d;
  axis_e              axis_q, axis_d;
  logic [2:0]         slot_q, slot_d;
  logic [W-1:0]       cube_q, cube_d;
  logic               zf_q, zf_d;
  logic [FIELD_W-1:0] ref_q, ref_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  cmd_t               in_cmd, head;
  logic               fifo_full, fifo_empty, pop;
  logic [MAX_W-1:0]   ext, rot;

  always_comb begin
    in_cmd = '{op:    op_e'(cmd_op),
               axis:  axis_e'(cmd_axis),
               turns: cmd_turns,
               slot:  cmd_slot};
  end

  cube_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (in_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= '0;
      op_q   <= OP_NOP;
      axis_q <= AX_X;
      slot_q <= '0;
      cube_q <= IDENT;
      zf_q   <= 1'b0;
      ref_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      axis_q <= axis_d;
      slot_q <= slot_d;
      cube_q <= cube_d;
      zf_q   <= zf_d;
      ref_q  <= ref_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    axis_d = axis_q;
    slot_d = slot_q;
    cube_d = cube_q;
    zf_d   = zf_q;
    ref_d  = ref_q;
    done_d = 1'b0;
    err_d  = err_q;
    ext    = '0;
    rot    = '0;
    // A pop makes busy high, so it always beats a load.
    if (load_valid) begin
      if (busy) err_d = 1'b1;
      else      cube_d = state_in;
    end
    unique case (fsm_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          op_d   = head.op;
          axis_d = head.axis;
          slot_d = head.slot;
          cnt_d  = (head.op == OP_ROT) ? head.turns : 2'd0;
          fsm_d  = S_EXEC;
          if (head.op == OP_ROT && head.axis == AX_RSV)
            err_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q != 2'd0) begin
          ext[W-1:0] = cube_q;
          rot        = rot_q(ext, axis_q, FIELD_W);
          cube_d     = rot[W-1:0];
          cnt_d      = cnt_q - 2'd1;
        end else begin
          unique case (1'b1)
            (op_q == OP_CHECK): zf_d = (cube_q == solved_ref);
            (op_q == OP_REF):
              ref_d = cube_q[slot_q*FIELD_W +: FIELD_W];
            default: ;
          endcase
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (fsm_q == S_IDLE) && !fifo_empty;
    busy      = (fsm_q != S_IDLE) || !fifo_empty;
    cmd_ready = !fifo_full;
    state     = cube_q;
    done      = done_q;
    zf        = zf_q;
    ref_out   = ref_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_cube_rot_engine.sv
// Directed bench for cube_rot_engine with hand-computed states.
// Inputs change and outputs are sampled on the falling edge.
module tb_cube_rot_engine;

  localparam int FW = 3;
  localparam int D  = 4;
  localparam int W  = 8 * FW;

  localparam logic [W-1:0] ID  = 24'hFAC688;
  localparam logic [W-1:0] X1  = 24'h7BC2A8;
  localparam logic [W-1:0] Y3  = 24'h7EC588;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [W-1:0]  state_in = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [1:0]    cmd_axis = '0;
  logic [1:0]    cmd_turns = '0;
  logic [2:0]    cmd_slot = '0;
  logic [W-1:0]  solved_ref = '0;
  logic [W-1:0]  state;
  logic          busy, done, zf, err;
  logic [FW-1:0] ref_out;

  int errs = 0;
  int checks = 0;
  logic [W-1:0] ytab [4];

  cube_rot_engine #(.FIELD_W(FW), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .state_in   (state_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_axis   (cmd_axis),
    .cmd_turns  (cmd_turns),
    .cmd_slot   (cmd_slot),
    .solved_ref (solved_ref),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .zf         (zf),
    .ref_out    (ref_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op,
                          input logic [1:0] ax,
                          input logic [1:0] tn,
                          input logic [2:0] sl);
    int n;
    n = 0;
    @(negedge clk);
    cmd_op    = op;
    cmd_axis  = ax;
    cmd_turns = tn;
    cmd_slot  = sl;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    load_valid = 1'b1;
    state_in   = v;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    int n, acc, dn, cyc;
    bit pushing, saw_full;
    ytab = '{24'hFAC688, 24'hCACEC8, 24'h4ECDC8, 24'h7EC588};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(ID));
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zf", 32'(zf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ref", 32'(ref_out), 32'd0);

    push_cmd(2'd0, 2'd0, 2'd1, 3'd0);
    wait_done(n);
    chk("x1_lat", 32'(n), 32'd3);
    chk("x1_state", 32'(state), 32'(X1));
    @(negedge clk);
    chk("x1_pulse", 32'(done), 32'd0);

    push_cmd(2'd0, 2'd0, 2'd2, 3'd0);
    push_cmd(2'd0, 2'd0, 2'd1, 3'd0);
    wait_done(n);
    wait_done(n);
    chk("x4_state", 32'(state), 32'(ID));

    solved_ref = ID;
    push_cmd(2'd1, 2'd0, 2'd3, 3'd0);
    wait_done(n);
    chk("chk1_lat", 32'(n), 32'd2);
    chk("chk1_zf", 32'(zf), 32'd1);
    solved_ref = '0;
    push_cmd(2'd1, 2'd0, 2'd0, 3'd0);
    wait_done(n);
    chk("chk0_zf", 32'(zf), 32'd0);

    load(X1);
    chk("load_state", 32'(state), 32'(X1));
    push_cmd(2'd2, 2'd0, 2'd0, 3'd5);
    wait_done(n);
    chk("ref5", 32'(ref_out), 32'd7);
    push_cmd(2'd2, 2'd0, 2'd0, 3'd0);
    wait_done(n);
    chk("ref0", 32'(ref_out), 32'd0);
    chk("ref_state", 32'(state), 32'(X1));
    chk("ref_zf_hold", 32'(zf), 32'd0);

    load(ID);
    acc = 0;
    dn = 0;
    cyc = 0;
    pushing = 1'b1;
    saw_full = 1'b0;
    @(negedge clk);
    cmd_op    = 2'd0;
    cmd_axis  = 2'd1;
    cmd_turns = 2'd3;
    cmd_valid = 1'b1;
    while ((pushing || busy) && cyc < 200) begin
      if (done) dn++;
      if (pushing) begin
        if (cmd_ready) acc++;
        else begin
          saw_full  = 1'b1;
          pushing   = 1'b0;
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (done) dn++;
    cmd_valid = 1'b0;
    chk("b2b_bounded", 32'(cyc < 200), 32'd1);
    chk("b2b_full", 32'(saw_full), 32'd1);
    chk("b2b_acc_ge", 32'(acc >= D), 32'd1);
    chk("b2b_dones", 32'(dn), 32'(acc));
    chk("b2b_state", 32'(state), 32'(ytab[(3*acc) % 4]));

    load(Y3);
    chk("err_pre", 32'(err), 32'd0);
    push_cmd(2'd0, 2'd3, 2'd2, 3'd0);
    wait_done(n);
    chk("rsv_lat", 32'(n), 32'd4);
    chk("rsv_state", 32'(state), 32'(Y3));
    chk("rsv_err", 32'(err), 32'd1);

    push_cmd(2'd3, 2'd0, 2'd0, 3'd0);
    chk("nop_busy", 32'(busy), 32'd1);
    load_valid = 1'b1;
    state_in   = '0;
    @(negedge clk);
    load_valid = 1'b0;
    wait_done(n);
    chk("busy_load_state", 32'(state), 32'(Y3));
    chk("busy_load_err", 32'(err), 32'd1);

    push_cmd(2'd0, 2'd2, 2'd3, 3'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 32'(ID));
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_rst_nodone", 32'(dn), 32'd0);
    chk("mid_rst_hold", 32'(state), 32'(ID));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cube_rot_engine.md
Name: cube_rot_engine

Overview:
- Sequential, parametrised successor to the cube-ALU rotation ops.
- Holds an 8-slot cube state word, with each slot FIELD_W bits wide.
- Accepts queued move/check/reference commands through a valid/ready handshake and a command FIFO.
- Executes rotations as iterated quarter turns, one per clock.
- Sits beside the CPU datapath as a coprocessor; the CPU loads state, streams moves, then polls done/zf/ref_out.

Parameters:
FIELD_W, 3, bits per slot; must be >= 3. State width W = 8*FIELD_W.
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
load_valid  in  1  load state_in into state register
state_in  in  W  new state value
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full; push occurs when cmd_valid && cmd_ready
cmd_op  in  2  0=ROT, 1=CHECK, 2=REF, 3=NOP
cmd_axis  in  2  0=X, 1=Y, 2=Z, 3=reserved
cmd_turns  in  2  quarter turns, 0..3
cmd_slot  in  3  slot index for REF
solved_ref  in  W  comparison word for CHECK
state  out  W  current cube state
busy  out  1  FSM not IDLE or FIFO not empty
done  out  1  one-cycle pulse per completed command
zf  out  1  result of last CHECK
ref_out  out  FIELD_W  result of last REF
err  out  1  sticky: reserved axis executed, or load while busy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high (rst); clk is the only clock.
- Reset values:
  - state = identity: slot i holds value i; slot i occupies bits [i*FIELD_W +: FIELD_W].
  - zf=0, ref_out=0, done=0, err=0.
  - FIFO empty, so cmd_ready=1 and busy=0. FSM=IDLE.
- Reset mid-operation: in-flight command and all queued commands are discarded.
- Quarter-turn permutations (dest <= src; all other slots unchanged):
  - X: s3<=s1, s7<=s3, s5<=s7, s1<=s5.
  - Y: s6<=s2, s7<=s6, s3<=s7, s2<=s3.
  - Z: s5<=s4, s7<=s5, s6<=s7, s4<=s6.
- FIFO:
  - cmd_ready = !full.
  - Push and pop in the same cycle are legal whenever not full.
  - Pointers wrap modulo FIFO_DEPTH. An explicit count distinguishes full from empty.
- FSM states: IDLE, EXEC.
  - IDLE, FIFO not empty: pop head, latch op/axis/slot, cnt <= turns (forced to 0 unless op=ROT), go to EXEC. This is edge E0.
  - IDLE, FIFO empty, load_valid=1: state <= state_in.
  - EXEC, cnt != 0: apply one quarter turn about the latched axis; cnt <= cnt-1.
  - EXEC, cnt == 0, by op, then done <= 1 and return to IDLE:
    - CHECK: zf <= (state == solved_ref).
    - REF: ref_out <= slot[cmd_slot].
    - ROT/NOP: no further action.
- Latency: a ROT with k turns updates state on edges E1..Ek; done is high in the cycle after edge E(k+1). CHECK, REF, NOP and ROT with turns=0 assert done after E1.
- Reserved axis=3 with ROT: state unchanged, err <= 1, and the command still consumes k+1 EXEC cycles and pulses done.
- load_valid while busy=1: ignored, err <= 1.
- load_valid in the same cycle as a pop: the pop wins and the load is ignored with err set, because busy=1.
- Back-to-back commands: the next pop occurs in the IDLE cycle after done. Throughput is one command per k+2 cycles.
- zf and ref_out hold their values until the next CHECK or REF respectively. err clears only on rst.

Decomposition:
- cube_pkg:
  - Op and axis encodings, NUM_SLOTS=8.
  - Per-axis quarter-turn source-index tables.
  - A function rot_q(state, axis) generic in FIELD_W.
- Sub-module cube_cmd_fifo: parametrised by DEPTH and entry width, 9 bits (op, axis, turns, slot).
- FSM, state register and result registers live in cube_rot_engine.

Test Plan:
- Reset, idle → state=0xFAC688, cmd_ready=1, busy=0, zf=0, err=0.
- ROT X turns=1 → one done pulse; state=0x7BC2A8 (slots 7..0 = 3,6,7,4,1,2,5,0).
- Queue after that turn:
  - ROT X turns=2, then ROT X turns=1 → state returns to 0xFAC688.
  - CHECK with solved_ref=0xFAC688 → zf=1.
  - CHECK with solved_ref=0 → zf=0.
- From 0x7BC2A8, REF slot=5 → ref_out=7; REF slot=0 → ref_out=0. state unchanged.
- Push ROT Y turns=3 commands back-to-back with cmd_valid held high:
  - cmd_ready drops once FIFO_DEPTH entries are queued.
  - Exactly the accepted count of done pulses follows.
  - Final state equals Y applied 3*accepted times.
- Error and reset cases:
  - ROT axis=3 turns=2 → state unchanged, done after 3 EXEC cycles, err=1.
  - load_valid during busy → ignored, err stays 1.
  - rst asserted mid-ROT → identity restored immediately; FIFO empty; no done pulse.
